// File: rtl/event_readout_decoder.sv
// Receive-side event decoder: polarity filter, group-first tagging and a valid/ready FIFO.
// Optional macro EVT_TIMESTAMP_EN adds a free-running timestamp field to each stored entry.
module event_readout_decoder #(
    parameter int ROW_W    = 3,
    parameter int COL_W    = 3,
    parameter int POLARITY = 2,
    parameter int WIDTH    = ROW_W + COL_W + POLARITY,
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 16,
    localparam int AW      = $clog2(DEPTH),
`ifdef EVT_TIMESTAMP_EN
    localparam bit TS_EN   = 1'b1,
`else
    localparam bit TS_EN   = 1'b0,
`endif
    localparam int OUT_W   = 1 + WIDTH + (TS_EN ? TS_WIDTH : 0)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             evt_valid_i,
    input  logic [WIDTH-1:0] evt_data_i,
    input  logic             grp_release_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic [AW:0]      fill_o,
    output logic             overflow_o,
    output logic [7:0]       drop_cnt_o
);

    logic [OUT_W-1:0]    mem [DEPTH];
    logic [AW:0]         wptr, rptr;
    logic [POLARITY-1:0] pol;
    logic                pol_ok, full, empty, pop, push, drop_full, drop;
    logic                grp_pend, grp_flag;
    logic [OUT_W-1:0]    wr_entry;

    assign pol    = evt_data_i[POLARITY-1:0];
    assign pol_ok = (pol == POLARITY'(1)) || (pol == POLARITY'(2));

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    assign out_valid_o = !empty;
    assign pop         = out_valid_o && out_ready_i;
    // a full FIFO still accepts when the head leaves on the same edge
    assign push        = evt_valid_i && pol_ok && (!full || pop);
    assign drop_full   = evt_valid_i && pol_ok && full && !pop;
    assign drop        = evt_valid_i && (!pol_ok || drop_full);

    // a release in the same cycle as an accepted event tags that event directly
    assign grp_flag = grp_pend || grp_release_i;

`ifdef EVT_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) ts_q <= '0;
        else          ts_q <= ts_q + 1'b1;
    end

    assign wr_entry = {grp_flag, ts_q, evt_data_i};
`else
    assign wr_entry = {grp_flag, evt_data_i};
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wptr       <= '0;
            rptr       <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
            grp_pend   <= 1'b1;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= wr_entry;
                wptr              <= wptr + 1'b1;
            end
            if (pop)       rptr       <= rptr + 1'b1;
            if (drop_full) overflow_o <= 1'b1;
            if (drop && drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
            if (push)               grp_pend <= 1'b0;
            else if (grp_release_i) grp_pend <= 1'b1;
        end
    end

    assign out_data_o = mem[rptr[AW-1:0]];
    assign fill_o     = wptr - rptr;

endmodule

// File: tb/tb_event_readout_decoder.sv
// Scoreboard bench for event_readout_decoder: stimulus pushes expected {grp_first, event},
// a negedge monitor pops and compares on every handshake.
module tb_event_readout_decoder;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
`ifdef EVT_TIMESTAMP_EN
    localparam int OUT_W = 1 + 16 + WIDTH;
`else
    localparam int OUT_W = 1 + WIDTH;
`endif

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic             evt_valid_i;
    logic [WIDTH-1:0] evt_data_i;
    logic             grp_release_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [OUT_W-1:0] out_data_o;
    logic [3:0]       fill_o;
    logic             overflow_o;
    logic [7:0]       drop_cnt_o;

    int checks = 0;
    int errors = 0;
    logic [WIDTH:0] sb[$];

    event_readout_decoder dut (
        .clk_i(clk_i), .reset_i(reset_i), .evt_valid_i(evt_valid_i),
        .evt_data_i(evt_data_i), .grp_release_i(grp_release_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .fill_o(fill_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [WIDTH-1:0] ev(input int row, input int col, input logic [1:0] pol);
        logic [2:0] r, c;
        r = 3'(row);
        c = 3'(col);
        return {r, c, pol};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && out_valid_o; k++) cyc();
        chk("drain_empty", out_valid_o, 0);
    endtask

    // monitor: compare the head on every accepting handshake
    always @(negedge clk_i) begin
        if (reset_i && out_valid_o && out_ready_i) begin
            logic [WIDTH:0] got, exp;
            got = {out_data_o[OUT_W-1], out_data_o[WIDTH-1:0]};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h expected none", got);
            end else begin
                exp = sb.pop_front();
                if (got != exp) begin
                    errors++;
                    $display("FAIL out_data: got %h expected %h", got, exp);
                end
            end
        end
    end

    initial begin
        reset_i = 1'b0; evt_valid_i = 1'b0; evt_data_i = '0;
        grp_release_i = 1'b0; out_ready_i = 1'b0;
        #12;
        chk("rst_valid", out_valid_o, 0);
        chk("rst_fill", fill_o, 0);
        chk("rst_overflow", overflow_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        chk("rst_data", int'(out_data_o), 0);
        @(negedge clk_i) reset_i = 1'b1;
        cyc();

        // single event, grp_first from reset exit
        out_ready_i = 1'b1;
        evt_valid_i = 1'b1; evt_data_i = ev(2, 5, 2'b01);
        sb.push_back({1'b1, ev(2, 5, 2'b01)});
        cyc();
        evt_valid_i = 1'b0;
        chk("t1_fill1", fill_o, 1);
        chk("t1_valid", out_valid_o, 1);
        cyc();
        chk("t1_fill0", fill_o, 0);
        chk("t1_valid0", out_valid_o, 0);

        // invalid polarities are dropped without overflow
        evt_valid_i = 1'b1; evt_data_i = ev(1, 1, 2'b00);
        cyc();
        evt_data_i = ev(1, 2, 2'b11);
        cyc();
        evt_valid_i = 1'b0;
        chk("t3_fill", fill_o, 0);
        chk("t3_drop", drop_cnt_o, 2);
        chk("t3_overflow", overflow_o, 0);

        // fill to full with consumer stalled, two overflow drops
        out_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            evt_valid_i = 1'b1;
            evt_data_i  = ev(i % 8, 7 - (i % 8), (i % 2) ? 2'b10 : 2'b01);
            if (i < DEPTH) sb.push_back({1'b0, evt_data_i});
            cyc();
        end
        evt_valid_i = 1'b0;
        chk("t2_fill", fill_o, 8);
        chk("t2_overflow", overflow_o, 1);
        chk("t2_drop", drop_cnt_o, 4);

        // push and pop on the same edge while full
        out_ready_i = 1'b1;
        evt_valid_i = 1'b1; evt_data_i = ev(7, 7, 2'b01);
        sb.push_back({1'b0, ev(7, 7, 2'b01)});
        cyc();
        evt_valid_i = 1'b0;
        chk("t4_fill", fill_o, 8);
        chk("t4_drop", drop_cnt_o, 4);
        drain();
        chk("t4_fill0", fill_o, 0);

        // release on idle cycle, then release coincident with an event
        grp_release_i = 1'b1;
        cyc();
        grp_release_i = 1'b0;
        evt_valid_i = 1'b1; evt_data_i = ev(3, 4, 2'b10);
        sb.push_back({1'b1, ev(3, 4, 2'b10)});
        cyc();
        evt_data_i = ev(4, 3, 2'b01);
        sb.push_back({1'b0, ev(4, 3, 2'b01)});
        cyc();
        grp_release_i = 1'b1; evt_data_i = ev(5, 6, 2'b01);
        sb.push_back({1'b1, ev(5, 6, 2'b01)});
        cyc();
        grp_release_i = 1'b0; evt_data_i = ev(6, 5, 2'b10);
        sb.push_back({1'b0, ev(6, 5, 2'b10)});
        cyc();
        evt_valid_i = 1'b0;
        drain();

        // asynchronous reset with five entries buffered
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            evt_valid_i = 1'b1; evt_data_i = ev(i, i, 2'b01);
            cyc();
        end
        evt_valid_i = 1'b0;
        chk("t6_fill5", fill_o, 5);
        #3 reset_i = 1'b0;
        #1;
        chk("t6_valid", out_valid_o, 0);
        chk("t6_fill", fill_o, 0);
        chk("t6_drop", drop_cnt_o, 0);
        chk("t6_overflow", overflow_o, 0);
        @(negedge clk_i) reset_i = 1'b1;
        cyc();
        out_ready_i = 1'b1;
        evt_valid_i = 1'b1; evt_data_i = ev(1, 6, 2'b10);
        sb.push_back({1'b1, ev(1, 6, 2'b10)});
        cyc();
        evt_valid_i = 1'b0;
        drain();

        // drop counter saturates
        evt_valid_i = 1'b1; evt_data_i = ev(0, 0, 2'b00);
        for (int i = 0; i < 260; i++) cyc();
        evt_valid_i = 1'b0;
        cyc();
        chk("sat_drop", drop_cnt_o, 255);
        chk("sat_fill", fill_o, 0);

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/event_readout_decoder.md
# event_readout_decoder

Receive-side endpoint for the pixel arbitration hierarchy: consumes the granted event words emitted by `top_pixel_hierarchy` (`data_out_o`, `grp_release_out_o`), decodes them into row/column/polarity fields, optionally timestamps them, and buffers them in a FIFO for a downstream valid/ready consumer. It sits directly after the top of the hierarchy and is the drain for every event the arbiter grants.

## Interface
- `ROW_W`, 3, row address width inside the event word
- `COL_W`, 3, column address width inside the event word
- `POLARITY`, 2, polarity field width (package constant)
- `WIDTH`, `ROW_W+COL_W+POLARITY`, event word width; packing `{row, col, pol}`, pol in LSBs
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `TS_WIDTH`, 16, timestamp width (used only with `EVT_TIMESTAMP_EN`)
- `clk_i`  in  1  clock
- `reset_i`  in  1  reset; asynchronous, active-low
- `evt_valid_i`  in  1  event word present this cycle
- `evt_data_i`  in  WIDTH  event word `{row, col, pol}`
- `grp_release_i`  in  1  group release from the hierarchy
- `out_valid_o`  out  1  FIFO head valid
- `out_ready_i`  in  1  consumer accepts head
- `out_data_o`  out  OUT_W  `{grp_first, [ts], row, col, pol}`; OUT_W = 1+WIDTH (+TS_WIDTH with timestamp)
- `fill_o`  out  $clog2(DEPTH)+1  current occupancy
- `overflow_o`  out  1  sticky: a valid event was dropped because FIFO full
- `drop_cnt_o`  out  8  saturating count of dropped events (full or invalid polarity)

## Operation
- Polarity decode: `2'b01` = ON, `2'b10` = OFF → accepted; `2'b00`, `2'b11` → invalid, not written, `drop_cnt_o` +1.
- Write condition: `evt_valid_i` && polarity valid && (!full || pop this cycle). Pop = `out_valid_o && out_ready_i`.
- Valid event when full and no pop: not written, `overflow_o` set, `drop_cnt_o` +1. Invalid-polarity and full in same cycle count once.
- `drop_cnt_o` saturates at 255; never wraps.
- `grp_first` flag: pending bit set at reset exit and on every `grp_release_i`; next written entry gets `grp_first=1`, pending clears on that write. `grp_release_i` with a same-cycle accepted event: that event is `grp_first=1`; pending does not remain set.
- FIFO: read/write pointers `$clog2(DEPTH)+1` bits, wrap naturally; full = MSBs differ, lower bits equal; empty = pointers equal. Simultaneous push and pop keeps `fill_o` unchanged, including at full and empty (push+pop at empty not possible since no head).
- `out_data_o` = memory at read pointer; held stable while `out_valid_o && !out_ready_i`.

## Timing
- Reset (`reset_i`=0, async): pointers, `fill_o`, `out_valid_o`, `overflow_o`, `drop_cnt_o`, timestamp all 0; `out_data_o` = 0; pending `grp_first` = 1. Mid-operation reset discards all buffered entries immediately.
- Latency: event accepted at edge N → `out_valid_o`=1 and `out_data_o` valid after edge N (visible cycle N+1) when FIFO was empty.
- Pop at edge N → next entry visible after edge N; `fill_o` updates the same edge.
- `overflow_o` asserts after the dropping edge; clears only on reset.

## Configuration
- `EVT_TIMESTAMP_EN` defined: free-running TS_WIDTH counter increments every cycle after reset, wraps to 0 at all-ones; accepted event stores counter value at its write edge; OUT_W = 1+TS_WIDTH+WIDTH.
- Not defined: no counter, no ts field; OUT_W = 1+WIDTH; all other behaviour identical.

## Test plan
- Reset, single event `{3'd2,3'd5,2'b01}`, `out_ready_i`=1 → `out_valid_o` one cycle, data `{1,2,5,01}` (grp_first=1), `fill_o` 1→0.
- `out_ready_i`=0, 10 valid events, DEPTH=8 → `fill_o`=8, `overflow_o`=1, `drop_cnt_o`=2; drain yields first 8 in order.
- Events with pol `2'b00` and `2'b11` → nothing written, `drop_cnt_o`=2, `overflow_o`=0.
- Full FIFO, push+pop same edge → event accepted, `fill_o` stays 8, no drop.
- `grp_release_i` idle cycle, then 2 events → first has grp_first=1, second 0; with `EVT_TIMESTAMP_EN` ts fields differ by write-cycle distance.
- Assert `reset_i`=0 with 5 entries buffered → `out_valid_o`=0, `fill_o`=0, `drop_cnt_o`=0 immediately (asynchronous).
